dds_tone_meter: RTL and testbench
=================================

// Module: dds_tone_meter
// PURPOSE
//  Receive-side companion to the DDS tone generator: takes the 8-bit unsigned sine sample stream and
//  measures its period across NPER cycles. Estimates the generator's 3-bit frequency select from the
//  measured period. Sits on the DDS output or on an ADC loopback; used for self-test and lock indication.
// PARAMETERS
//  DATA_W   8     sample width, unsigned, midscale = 2**(DATA_W-1)
//  HYST     16    hysteresis half-width around midscale, in LSBs
//  NPER     4     periods per measurement; must be a power of 2; NPER_LOG2 = $clog2(NPER)
//  CNT_W    16    sample counter / period output width
//  TIMEOUT  4095  samples without completing a measurement before timeout
// PORTS
//  clk          in   1       clock
//  rst_n        in   1       reset, asynchronous, active-low
//  en           in   1       meter enable; 0 = idle, clear state
//  din_valid    in   1       din qualifier; nothing advances when 0
//  din          in   DATA_W  unsigned sample
//  period       out  CNT_W   samples spanning the last NPER periods
//  period_valid out  1       1-cycle pulse: period and f_sel_est updated
//  f_sel_est    out  3       estimated select (0..6, fword-1)
//  locked       out  1       two consecutive equal estimates
//  timeout      out  1       1-cycle pulse: no measurement within TIMEOUT samples
// BEHAVIOUR
//  Reset: period=0, f_sel_est=0, period_valid=0, locked=0, timeout=0, state=IDLE, counters=0, hi=0.
//  Crossing detector (valid samples only):
//   - hi<=1 when din >= MID+HYST (144); hi<=0 when din <= MID-HYST (112); otherwise hold.
//   - xing = din_valid & ~hi & (din >= MID+HYST), i.e. a rising crossing.
//  FSM: IDLE, SYNC, MEAS.
//   - IDLE: en=1 -> SYNC.
//   - SYNC: on xing -> MEAS; cnt=0, ncross=0.
//   - MEAS: each valid sample cnt++ (counts the sample that carries the final xing); xing -> ncross++.
//     On the NPER-th xing:
//      - register period=cnt+1; period_valid pulses the next cycle.
//      - stay in MEAS with cnt=0, ncross=0: back-to-back measurements, that crossing is the new sync point.
//  Estimate: P = period >> NPER_LOG2. Thresholds assume 9-bit phase (512 samples at fword=1):
//   - P>=384 -> 0; >=213 -> 1; >=149 -> 2; >=115 -> 3; >=94 -> 4; >=79 -> 5; else 6.
//   - f_sel_est is registered together with period.
//  Timeout: cnt reaching TIMEOUT in SYNC or MEAS -> timeout pulse, locked=0, go to SYNC, cnt=0.
//   - A xing on that same sample completing NPER takes precedence; no timeout.
//   - cnt never wraps: TIMEOUT < 2**CNT_W.
//  en=0 in any state: next cycle IDLE, counters/hi cleared, locked=0; period/f_sel_est hold last value.
//  rst_n asserted mid-measurement: immediate reset values; no period_valid emitted.
//  Input latency: sample in -> period_valid = 1 clk after the completing sample.
// CONFIGURATION
//  DDS_METER_LOCK_EN defined:
//   - locked is set on period_valid when the new f_sel_est equals the previous one.
//   - locked is cleared on a differing estimate, on timeout, and on en=0.
//  Not defined: locked tied 0; previous-estimate register omitted.
// STRUCTURE
//  Package dds_meter_pkg:
//   - state enum {IDLE,SYNC,MEAS}.
//   - P threshold constants (384,213,149,115,94,79).
//   - MID localparam function of DATA_W.
//  Sub-module dds_xing_det: hysteresis comparator + rising-edge; out xing.
//  Top: FSM, counters, estimator, lock.
// TESTING (DDS generator as source, din_valid=1 every clk unless stated, NPER=4)
//  1 f_sel=0, en=1 -> after sync, period=2048 every 2048 clk, f_sel_est=0, locked after 2nd pulse.
//  2 f_sel=3 (fword 4) -> period=512, f_sel_est=3, locked=1.
//  3 f_sel=6 (fword 7) -> period in 292..293, f_sel_est=6, no timeout.
//  4 din=128 constant, or 128+/-10 noise -> no xing; timeout pulse at sample 4095, repeats; locked=0.
//  5 f_sel 0->1 mid-run -> locked=0 after first differing estimate; relock at f_sel_est=1 after two
//    equal estimates (period=1024).
//  6 en=0 / rst_n pulse mid-MEAS -> IDLE, no period_valid, locked=0; din_valid gaps -> period unchanged.

Source files
------------

// File: rtl/dds_meter_pkg.sv
// Shared definitions for the DDS tone meter.
// Contents: FSM state encoding, period-per-cycle thresholds for the frequency
// select estimator, and the midscale helper for unsigned sample streams.
package dds_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    MEAS = 2'd2
  } state_t;

  // Samples per single sine period at each select, for a 9-bit phase
  // accumulator (512 samples at fword=1). Boundaries sit between neighbours.
  localparam int P_TH_F0 = 384;
  localparam int P_TH_F1 = 213;
  localparam int P_TH_F2 = 149;
  localparam int P_TH_F3 = 115;
  localparam int P_TH_F4 = 94;
  localparam int P_TH_F5 = 79;

  localparam int DATA_W_DFLT = 8;

  function automatic int mid_of(input int data_w);
    return 1 << (data_w - 1);
  endfunction

  localparam int MID = mid_of(DATA_W_DFLT);

endpackage

// File: rtl/dds_tone_meter_xing.sv
// Rising midscale-crossing detector with hysteresis.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   i_clr         synchronous clear of the hysteresis state
//   i_din_valid   sample qualifier; state only moves on valid samples
//   i_din         unsigned sample
//   o_xing        combinational: this valid sample is a rising crossing
module dds_xing_det
  import dds_meter_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int HYST   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_din_valid,
  input  logic [DATA_W-1:0] i_din,
  output logic              o_xing
);

  localparam logic [DATA_W-1:0] TH_HI = DATA_W'(mid_of(DATA_W) + HYST);
  localparam logic [DATA_W-1:0] TH_LO = DATA_W'(mid_of(DATA_W) - HYST);

  logic r_hi;
  logic w_above;
  logic w_below;

  assign w_above = (i_din >= TH_HI);
  assign w_below = (i_din <= TH_LO);

  // Between the thresholds the previous level is held, so noise around
  // midscale cannot produce extra crossings.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= 1'b0;
    end else if (i_clr) begin
      r_hi <= 1'b0;
    end else if (i_din_valid) begin
      if (w_above) begin
        r_hi <= 1'b1;
      end else if (w_below) begin
        r_hi <= 1'b0;
      end
    end
  end

  assign o_xing = i_din_valid & ~r_hi & w_above;

endmodule

// File: rtl/dds_tone_meter.sv
// DDS tone meter: measures the sample count spanning NPER sine periods and
// estimates the generator's 3-bit frequency select from it.
// Configuration: define DDS_METER_LOCK_EN to enable lock indication;
// otherwise locked is tied low.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   en             meter enable; low returns to idle and clears state
//   din_valid      sample qualifier
//   din            unsigned sample
//   period         samples spanning the last NPER periods
//   period_valid   one-cycle pulse when period/f_sel_est update
//   f_sel_est      estimated frequency select (0..6)
//   locked         two consecutive equal estimates
//   timeout        one-cycle pulse when no measurement completes in time
module dds_tone_meter
  import dds_meter_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int HYST    = 16,
  parameter int NPER    = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 4095
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din,
  output logic [CNT_W-1:0]  period,
  output logic              period_valid,
  output logic [2:0]        f_sel_est,
  output logic              locked,
  output logic              timeout
);

  localparam int NPER_LOG2 = $clog2(NPER);
  localparam int NC_W      = NPER_LOG2 + 1;

  function automatic logic [2:0] est_fsel(input logic [CNT_W-1:0] per_in);
    logic [CNT_W-1:0] p;
    p = per_in >> NPER_LOG2;
    if      (p >= CNT_W'(P_TH_F0)) return 3'd0;
    else if (p >= CNT_W'(P_TH_F1)) return 3'd1;
    else if (p >= CNT_W'(P_TH_F2)) return 3'd2;
    else if (p >= CNT_W'(P_TH_F3)) return 3'd3;
    else if (p >= CNT_W'(P_TH_F4)) return 3'd4;
    else if (p >= CNT_W'(P_TH_F5)) return 3'd5;
    else                           return 3'd6;
  endfunction

  logic             w_xing;
  logic             w_clr;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [NC_W-1:0]  r_ncross, w_ncross_nxt, w_ncross_inc;
  logic             w_done;
  logic             w_to;
  logic [2:0]       w_est;
  logic [CNT_W-1:0] r_period;
  logic [2:0]       r_f_sel_est;
  logic             r_period_valid;
  logic             r_timeout;

  assign w_clr = ~en;

  dds_xing_det #(
    .DATA_W (DATA_W),
    .HYST   (HYST)
  ) u_xing (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (w_clr),
    .i_din_valid (din_valid),
    .i_din       (din),
    .o_xing      (w_xing)
  );

  assign w_cnt_inc    = r_cnt + CNT_W'(1);
  assign w_ncross_inc = r_ncross + NC_W'(1);
  assign w_est        = est_fsel(w_cnt_inc);

  // The crossing that completes NPER periods wins over a coincident timeout;
  // the crossing that starts a measurement in SYNC does too.
  assign w_done = en & din_valid & w_xing & (r_state == MEAS) &
                  (w_ncross_inc == NC_W'(NPER));
  assign w_to   = en & din_valid & (r_state != IDLE) & ~w_done &
                  ~((r_state == SYNC) & w_xing) &
                  (w_cnt_inc == CNT_W'(TIMEOUT));

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_ncross_nxt = r_ncross;
    if (!en) begin
      w_state_nxt  = IDLE;
      w_cnt_nxt    = '0;
      w_ncross_nxt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt  = SYNC;
          w_cnt_nxt    = '0;
          w_ncross_nxt = '0;
        end
        SYNC: begin
          if (din_valid) begin
            if (w_xing) begin
              w_state_nxt  = MEAS;
              w_cnt_nxt    = '0;
              w_ncross_nxt = '0;
            end else if (w_to) begin
              w_cnt_nxt = '0;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end
        end
        MEAS: begin
          if (din_valid) begin
            // The completing crossing becomes the next sync point.
            if (w_done) begin
              w_cnt_nxt    = '0;
              w_ncross_nxt = '0;
            end else if (w_to) begin
              w_state_nxt  = SYNC;
              w_cnt_nxt    = '0;
              w_ncross_nxt = '0;
            end else begin
              w_cnt_nxt = w_cnt_inc;
              if (w_xing) begin
                w_ncross_nxt = w_ncross_inc;
              end
            end
          end
        end
        default: begin
          w_state_nxt  = IDLE;
          w_cnt_nxt    = '0;
          w_ncross_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_ncross <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ncross <= w_ncross_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period       <= '0;
      r_f_sel_est    <= '0;
      r_period_valid <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      r_period_valid <= w_done;
      r_timeout      <= w_to;
      if (w_done) begin
        r_period    <= w_cnt_inc;
        r_f_sel_est <= w_est;
      end
    end
  end

`ifdef DDS_METER_LOCK_EN
  logic r_locked;
  logic r_prev_vld;

  // r_f_sel_est still holds the previous estimate when w_done is evaluated;
  // r_prev_vld says whether that previous estimate belongs to this run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_locked   <= 1'b0;
      r_prev_vld <= 1'b0;
    end else if (!en) begin
      r_locked   <= 1'b0;
      r_prev_vld <= 1'b0;
    end else if (w_done) begin
      r_locked   <= r_prev_vld & (w_est == r_f_sel_est);
      r_prev_vld <= 1'b1;
    end else if (w_to) begin
      r_locked   <= 1'b0;
      r_prev_vld <= 1'b0;
    end
  end

  assign locked = r_locked;
`else
  assign locked = 1'b0;
`endif

  assign period       = r_period;
  assign period_valid = r_period_valid;
  assign f_sel_est    = r_f_sel_est;
  assign timeout      = r_timeout;

endmodule

// File: tb/tb_dds_tone_meter.sv
module tb_dds_tone_meter;

  localparam int NPER    = 4;
  localparam int TIMEOUT = 4095;
`ifdef DDS_METER_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        din_valid;
  logic [7:0]  din;
  logic [15:0] period;
  logic        period_valid;
  logic [2:0]  f_sel_est;
  logic        locked;
  logic        timeout;

  dds_tone_meter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .din_valid    (din_valid),
    .din          (din),
    .period       (period),
    .period_valid (period_valid),
    .f_sel_est    (f_sel_est),
    .locked       (locked),
    .timeout      (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard entries: kind 0 = period result, kind 1 = timeout.
  typedef struct {
    int     kind;
    int     per;
    int     est;
    int     lk;
    longint cyc;
  } exp_t;
  exp_t q[$];

  // Reference model: measures distance in valid-sample index between the
  // sync crossing and the NPER-th following crossing.
  int m_mode;       // 0 idle, 1 waiting for sync, 2 measuring
  int m_hi;
  int m_vidx;
  int m_ref;
  int m_nx;
  int m_prev_vld;
  int m_last_est;
  int m_locked;
  int m_period;
  int m_est_reg;

  function automatic int est_of(input int per);
    int p;
    p = per / NPER;
    if (p >= 384) return 0;
    if (p >= 213) return 1;
    if (p >= 149) return 2;
    if (p >= 115) return 3;
    if (p >= 94)  return 4;
    if (p >= 79)  return 5;
    return 6;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_hi = 0; m_vidx = 0; m_ref = 0; m_nx = 0;
    m_prev_vld = 0; m_last_est = 0; m_locked = 0; m_period = 0; m_est_reg = 0;
  endtask

  task automatic push_timeout();
    exp_t e;
    m_locked = 0;
    m_prev_vld = 0;
    m_ref = m_vidx;
    m_nx = 0;
    e.kind = 1; e.per = 0; e.est = 0; e.lk = 0; e.cyc = cyc + 1;
    q.push_back(e);
  endtask

  task automatic push_done();
    exp_t e;
    int per, est;
    per = m_vidx - m_ref;
    est = est_of(per);
    m_locked = (m_prev_vld != 0 && est == m_last_est) ? 1 : 0;
    m_prev_vld = 1;
    m_last_est = est;
    m_period = per;
    m_est_reg = est;
    m_ref = m_vidx;
    m_nx = 0;
    e.kind = 0; e.per = per; e.est = est; e.lk = m_locked; e.cyc = cyc + 1;
    q.push_back(e);
  endtask

  task automatic model_sample(input bit e, input bit v, input int d);
    bit x;
    if (!e) begin
      m_mode = 0; m_hi = 0; m_locked = 0; m_prev_vld = 0; m_nx = 0;
      return;
    end
    x = v && (m_hi == 0) && (d >= 144);
    if (v) begin
      if (d >= 144) m_hi = 1;
      else if (d <= 112) m_hi = 0;
    end
    case (m_mode)
      0: begin
        m_mode = 1;
        m_ref = m_vidx;
      end
      1: if (v) begin
        m_vidx++;
        if (x) begin
          m_mode = 2; m_ref = m_vidx; m_nx = 0;
        end else if (m_vidx - m_ref == TIMEOUT) begin
          push_timeout();
        end
      end
      default: if (v) begin
        m_vidx++;
        if (x) m_nx++;
        if (x && m_nx == NPER) begin
          push_done();
        end else if (m_vidx - m_ref == TIMEOUT) begin
          push_timeout();
          m_mode = 1;
        end
      end
    endcase
  endtask

  // Monitor: pops one expectation per DUT output pulse.
  always @(negedge clk) begin
    if (rst_n && (period_valid || timeout)) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: period_valid=%0b timeout=%0b with empty scoreboard (cycle %0d)",
                 period_valid, timeout, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_kind", period_valid ? 0 : 1, e.kind);
        chk("pulse_cycle", cyc, e.cyc);
        if (e.kind == 0) begin
          chk("period", period, e.per);
          chk("f_sel_est", f_sel_est, e.est);
        end
        chk("locked_at_pulse", locked, LOCK_EN ? e.lk : 0);
      end
    end
  end

  int phase = 0;

  task automatic step(input bit e, input bit v, input int d);
    en = e;
    din_valid = v;
    din = d[7:0];
    model_sample(e, v, d);
    @(posedge clk);
    #1;
  endtask

  task automatic run_dds(input int fsel, input int n, input int pct, input int noise);
    for (int i = 0; i < n; i++) begin
      bit v;
      int d;
      v = ($urandom_range(0, 99) < pct);
      if (v) phase = (phase + fsel + 1) % 512;
      d = $rtoi(128.0 + 120.0 * $sin(2.0 * 3.14159265358979 * phase / 512.0) + 0.5);
      if (noise > 0) d = d + int'($urandom_range(0, 2 * noise)) - noise;
      if (d < 0) d = 0;
      if (d > 255) d = 255;
      step(1'b1, v, d);
    end
  endtask

  task automatic run_const(input int n, input int amp);
    for (int i = 0; i < n; i++) begin
      int d;
      d = 128;
      if (amp > 0) d = d + int'($urandom_range(0, 2 * amp)) - amp;
      step(1'b1, 1'b1, d);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_f_sel_est"}, f_sel_est, 0);
    chk({tag, "_period_valid"}, period_valid, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_timeout"}, timeout, 0);
  endtask

  initial begin
    en = 1'b0;
    din_valid = 1'b0;
    din = 8'd128;
    rst_n = 1'b0;
    model_reset();
    repeat (4) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    step(1'b0, 1'b0, 128);

    // f_sel=0: 2048 samples per measurement
    phase = $urandom_range(0, 511);
    run_dds(0, 2048 * 5 + 600, 100, 0);
    chk("f0_period", period, 2048);
    chk("f0_est", f_sel_est, 0);
    chk("f0_locked", locked, LOCK_EN ? 1 : 0);

    // f_sel=3: 512 samples
    run_dds(3, 512 * 4 * 4, 100, 0);
    chk("f3_period", period, 512);
    chk("f3_est", f_sel_est, 3);

    // f_sel=6: 292..293 samples
    run_dds(6, 293 * 4 * 4, 100, 0);
    chk("f6_period_in_range", (period >= 292 && period <= 293) ? 1 : 0, 1);
    chk("f6_est", f_sel_est, 6);

    // No crossings: constant midscale, then small noise -> repeated timeouts
    run_const(4300, 0);
    run_const(4300, 10);
    chk("noxing_locked", locked, 0);
    chk("noxing_period_held", period, m_period);

    // f_sel change 0 -> 1, relock at 1024
    run_dds(0, 2048 * 3, 100, 0);
    run_dds(1, 1024 * 4 * 3, 100, 0);
    chk("f1_period", period, 1024);
    chk("f1_est", f_sel_est, 1);
    chk("f1_locked", locked, LOCK_EN ? 1 : 0);

    // en=0 mid-measurement
    run_dds(3, 1000, 100, 0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 200);
    chk("en0_locked", locked, 0);
    chk("en0_period_held", period, m_period);
    chk("en0_est_held", f_sel_est, m_est_reg);
    run_dds(3, 3000, 100, 0);

    // Asynchronous reset mid-measurement
    run_dds(3, 700, 100, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_vals("midreset");
    chk("midreset_queue_empty", q.size(), 0);
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 128);

    // din_valid gaps: period measured in valid samples is unchanged
    run_dds(3, 512 * 4 * 6, 60, 0);
    chk("gaps_period", period, 512);
    chk("gaps_est", f_sel_est, 3);

    // Randomized selects with noise and gaps
    for (int s = 0; s < 4; s++) begin
      int fs;
      fs = $urandom_range(0, 6);
      run_dds(fs, 2500 + 300 * (6 - fs), 85, 3);
    end

    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 128);
    chk("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
